// File: rtl/arq_seqn_ctrl.sv
// arq_seqn_ctrl: baseband ARQ / SEQN / flow-control stage.
// Takes decoded header fields and the payload CRC verdict from the header
// processor. Keeps the per-LT_ADDR SEQN/ARQN bits and the FLOW bit that go into
// the next transmitted header.
// Optional build macro: ARQ_SEQN_STATS_EN adds saturating dup_cnt/nak_cnt outputs.
//
// Ports:
//   clk_6M, rstz           6 MHz clock, async active-low reset
//   p_1us                  1 us strobe; every event is sampled only on it
//   conns                  connection state; when low, everything is held in reset values
//   tx_packet_st_p, txpk_lt_addr, txpktype    local transmission start
//   ckheader_endp, dec_hecgood, lt_addressed, dec_lt_addr, dec_pk_type,
//   dec_seqn, dec_arqn     received header results
//   py_endp, py_crcgood    received payload end and its CRC verdict
//   rx_buf_full            receive buffer cannot take another payload
//   txaclSEQN, txARQN      per-LT SEQN / ARQN to transmit
//   rspFLOW                FLOW bit to transmit
//   tx_pend                per-LT data awaiting ACK
//   tx_ack_p, rx_accept_p, rx_dup_p   one-cycle event pulses
//   dup_cnt, nak_cnt       (ARQ_SEQN_STATS_EN only) saturating event counters
module arq_seqn_ctrl #(
  parameter int unsigned PY_TIMEOUT_US = 3000,
  parameter int unsigned TOW           = 12
) (
  input  logic       clk_6M,
  input  logic       rstz,
  input  logic       p_1us,
  input  logic       conns,
  input  logic       tx_packet_st_p,
  input  logic [2:0] txpk_lt_addr,
  input  logic [3:0] txpktype,
  input  logic       ckheader_endp,
  input  logic       dec_hecgood,
  input  logic       lt_addressed,
  input  logic [2:0] dec_lt_addr,
  input  logic [3:0] dec_pk_type,
  input  logic       dec_seqn,
  input  logic [7:0] dec_arqn,
  input  logic       py_endp,
  input  logic       py_crcgood,
  input  logic       rx_buf_full,
  output logic [7:0] txaclSEQN,
  output logic [7:0] txARQN,
  output logic       rspFLOW,
  output logic [7:0] tx_pend,
  output logic       tx_ack_p,
  output logic       rx_accept_p,
  output logic       rx_dup_p
`ifdef ARQ_SEQN_STATS_EN
  ,
  output logic [7:0] dup_cnt,
  output logic [7:0] nak_cnt
`endif
);

  typedef enum logic {
    IDLE    = 1'b0,
    WAIT_PY = 1'b1
  } state_t;

  state_t         state;
  logic [TOW-1:0] timer;
  logic [2:0]     wait_lt;
  logic [7:0]     rx_last_seqn;
  logic [7:0]     seqn_valid;

  logic       tick;
  logic       hdr_ok;
  logic       ack_hit;
  logic       tx_set;
  logic       py_ev;
  logic       to_ev;
  logic       good_ev;
  logic       nak_ev;
  logic       acc_ev;
  logic       dup_ev;
  logic [7:0] pend_nxt;

  // NULL, POLL and FHS carry no ARQ-protected payload.
  function automatic logic is_data(input logic [3:0] t);
    return t > 4'd2;
  endfunction

  // Per-strobe event decode.
  always_comb begin
    tick     = p_1us & conns;
    hdr_ok   = tick & (state == IDLE) & ckheader_endp & dec_hecgood & lt_addressed;
    ack_hit  = hdr_ok & dec_arqn[dec_lt_addr] & tx_pend[dec_lt_addr];
    tx_set   = tick & tx_packet_st_p & is_data(txpktype);
    py_ev    = tick & (state == WAIT_PY) & py_endp;
    // A payload end in the same strobe as timer expiry takes priority.
    to_ev    = tick & (state == WAIT_PY) & ~py_endp & (timer == '0);
    good_ev  = py_ev & py_crcgood & ~rx_buf_full;
    nak_ev   = (py_ev & ~good_ev) | to_ev;
    acc_ev   = good_ev & (~seqn_valid[wait_lt] | (dec_seqn != rx_last_seqn[wait_lt]));
    dup_ev   = good_ev & ~acc_ev;
    // The ACK clears the bit first, so a new transmission in the same strobe re-arms it.
    pend_nxt = tx_pend;
    if (ack_hit) pend_nxt[dec_lt_addr] = 1'b0;
    if (tx_set)  pend_nxt[txpk_lt_addr] = 1'b1;
  end

  // State, timer and ARQ bookkeeping.
  always_ff @(posedge clk_6M or negedge rstz) begin
    if (!rstz) begin
      state        <= IDLE;
      timer        <= '0;
      wait_lt      <= '0;
      rx_last_seqn <= 8'h00;
      seqn_valid   <= 8'h00;
      txaclSEQN    <= 8'hff;
      txARQN       <= 8'h00;
      rspFLOW      <= 1'b1;
      tx_pend      <= 8'h00;
      tx_ack_p     <= 1'b0;
      rx_accept_p  <= 1'b0;
      rx_dup_p     <= 1'b0;
    end else if (!conns) begin
      state        <= IDLE;
      timer        <= '0;
      wait_lt      <= '0;
      rx_last_seqn <= 8'h00;
      seqn_valid   <= 8'h00;
      txaclSEQN    <= 8'hff;
      txARQN       <= 8'h00;
      rspFLOW      <= 1'b1;
      tx_pend      <= 8'h00;
      tx_ack_p     <= 1'b0;
      rx_accept_p  <= 1'b0;
      rx_dup_p     <= 1'b0;
    end else begin
      tx_ack_p    <= ack_hit;
      rx_accept_p <= acc_ev;
      rx_dup_p    <= dup_ev;
      tx_pend     <= pend_nxt;
      if (p_1us) rspFLOW <= ~rx_buf_full;
      if (ack_hit) txaclSEQN[dec_lt_addr] <= ~txaclSEQN[dec_lt_addr];
      if (nak_ev)  txARQN[wait_lt] <= 1'b0;
      if (good_ev) txARQN[wait_lt] <= 1'b1;
      if (acc_ev) begin
        rx_last_seqn[wait_lt] <= dec_seqn;
        seqn_valid[wait_lt]   <= 1'b1;
      end
      if (p_1us) begin
        case (state)
          IDLE: begin
            if (hdr_ok && is_data(dec_pk_type)) begin
              state   <= WAIT_PY;
              timer   <= TOW'(PY_TIMEOUT_US);
              wait_lt <= dec_lt_addr;
            end
          end
          WAIT_PY: begin
            if (py_endp || (timer == '0)) state <= IDLE;
            else                          timer <= timer - TOW'(1);
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef ARQ_SEQN_STATS_EN
  // Saturating duplicate / NAK counters.
  always_ff @(posedge clk_6M or negedge rstz) begin
    if (!rstz) begin
      dup_cnt <= 8'h00;
      nak_cnt <= 8'h00;
    end else if (!conns) begin
      dup_cnt <= 8'h00;
      nak_cnt <= 8'h00;
    end else begin
      if (dup_ev && (dup_cnt != 8'hff)) dup_cnt <= dup_cnt + 8'd1;
      if (nak_ev && (nak_cnt != 8'hff)) nak_cnt <= nak_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_arq_seqn_ctrl.sv
// Self-checking bench for arq_seqn_ctrl: directed table, multi-cycle corner
// sequences, then random traffic against a behavioural model.
module tb_arq_seqn_ctrl;

  localparam int unsigned PY_TIMEOUT_US = 3000;

  logic       clk_6M = 1'b0;
  logic       rstz, p_1us, conns, tx_packet_st_p;
  logic [2:0] txpk_lt_addr, dec_lt_addr;
  logic [3:0] txpktype, dec_pk_type;
  logic       ckheader_endp, dec_hecgood, lt_addressed, dec_seqn;
  logic [7:0] dec_arqn;
  logic       py_endp, py_crcgood, rx_buf_full;
  logic [7:0] txaclSEQN, txARQN, tx_pend;
  logic       rspFLOW, tx_ack_p, rx_accept_p, rx_dup_p;
`ifdef ARQ_SEQN_STATS_EN
  logic [7:0] dup_cnt, nak_cnt;
`endif

  always #5 clk_6M = ~clk_6M;

  arq_seqn_ctrl #(.PY_TIMEOUT_US(PY_TIMEOUT_US), .TOW(12)) dut (
    .clk_6M(clk_6M), .rstz(rstz), .p_1us(p_1us), .conns(conns),
    .tx_packet_st_p(tx_packet_st_p), .txpk_lt_addr(txpk_lt_addr), .txpktype(txpktype),
    .ckheader_endp(ckheader_endp), .dec_hecgood(dec_hecgood), .lt_addressed(lt_addressed),
    .dec_lt_addr(dec_lt_addr), .dec_pk_type(dec_pk_type), .dec_seqn(dec_seqn),
    .dec_arqn(dec_arqn), .py_endp(py_endp), .py_crcgood(py_crcgood),
    .rx_buf_full(rx_buf_full), .txaclSEQN(txaclSEQN), .txARQN(txARQN), .rspFLOW(rspFLOW),
    .tx_pend(tx_pend), .tx_ack_p(tx_ack_p), .rx_accept_p(rx_accept_p), .rx_dup_p(rx_dup_p)
`ifdef ARQ_SEQN_STATS_EN
    , .dup_cnt(dup_cnt), .nak_cnt(nak_cnt)
`endif
  );

  typedef struct {
    bit       conns, tx, hdr, hec, addr, py, crc, full, seqn;
    bit [2:0] tx_lt, lt;
    bit [3:0] tx_type, ptype;
    bit [7:0] arqn;
  } vec_t;

  typedef struct {
    vec_t     v;
    bit [7:0] seqn_o, arqn_o, pend_o;
    bit       flow, ack, acc, dup;
  } row_t;

  int errors = 0;
  int checks = 0;

  // Behavioural model: per-LT arrays, a "waiting" flag and elapsed-microsecond arithmetic.
  bit [7:0] m_seqn, m_arqn, m_pend, m_last, m_valid, m_dup, m_nak;
  bit       m_flow, m_wait, e_ack, e_acc, e_dup;
  bit [2:0] m_lt;
  int       m_hdr_us, now_us;

  function automatic vec_t mk(bit c, bit tx, int tl, int tt, bit h, bit a, int lt, int pt,
                              bit sq, bit [7:0] aq, bit py, bit crc, bit full);
    vec_t v;
    v.conns = c; v.tx = tx; v.tx_lt = 3'(tl); v.tx_type = 4'(tt);
    v.hdr = h; v.hec = h; v.addr = a; v.lt = 3'(lt); v.ptype = 4'(pt);
    v.seqn = sq; v.arqn = aq; v.py = py; v.crc = crc; v.full = full;
    return v;
  endfunction

  function automatic row_t rw(vec_t v, bit [7:0] s, bit [7:0] a, bit [7:0] p,
                              bit f, bit k, bit c, bit d);
    row_t r;
    r.v = v; r.seqn_o = s; r.arqn_o = a; r.pend_o = p;
    r.flow = f; r.ack = k; r.acc = c; r.dup = d;
    return r;
  endfunction

  task automatic m_reset();
    m_seqn = 8'hff; m_arqn = 8'h00; m_pend = 8'h00; m_last = 8'h00; m_valid = 8'h00;
    m_flow = 1'b1; m_wait = 1'b0; m_lt = 3'd0; m_dup = 8'h00; m_nak = 8'h00;
  endtask

  task automatic m_nak_one();
    m_arqn[m_lt] = 1'b0;
    if (m_nak != 8'hff) m_nak++;
  endtask

  task automatic model(input vec_t v);
    e_ack = 1'b0; e_acc = 1'b0; e_dup = 1'b0;
    now_us++;
    if (!v.conns) begin
      m_reset();
      return;
    end
    if (!m_wait) begin
      if (v.hdr && v.hec && v.addr) begin
        if (v.arqn[v.lt] && m_pend[v.lt]) begin
          m_seqn[v.lt] = ~m_seqn[v.lt]; m_pend[v.lt] = 1'b0; e_ack = 1'b1;
        end
        if (v.ptype > 4'd2) begin
          m_wait = 1'b1; m_lt = v.lt; m_hdr_us = now_us;
        end
      end
    end else if (v.py) begin
      if (!v.crc || v.full) m_nak_one();
      else if (!m_valid[m_lt] || (v.seqn != m_last[m_lt])) begin
        m_last[m_lt] = v.seqn; m_valid[m_lt] = 1'b1; m_arqn[m_lt] = 1'b1; e_acc = 1'b1;
      end else begin
        m_arqn[m_lt] = 1'b1; e_dup = 1'b1;
        if (m_dup != 8'hff) m_dup++;
      end
      m_wait = 1'b0;
    end else if (now_us - m_hdr_us > int'(PY_TIMEOUT_US)) begin
      m_nak_one();
      m_wait = 1'b0;
    end
    if (v.tx && v.tx_type > 4'd2) m_pend[v.tx_lt] = 1'b1;
    m_flow = ~v.full;
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t v);
    conns = v.conns; tx_packet_st_p = v.tx; txpk_lt_addr = v.tx_lt; txpktype = v.tx_type;
    ckheader_endp = v.hdr; dec_hecgood = v.hec; lt_addressed = v.addr;
    dec_lt_addr = v.lt; dec_pk_type = v.ptype; dec_seqn = v.seqn; dec_arqn = v.arqn;
    py_endp = v.py; py_crcgood = v.crc; rx_buf_full = v.full;
  endtask

  // One microsecond: strobe cycle (checked), then a quiet cycle (pulses must be gone).
  task automatic step(input vec_t v, input bit use_row, input row_t r);
    bit [7:0] xs, xa, xp;
    bit       xf, xk, xc, xd;
    model(v);
    if (use_row) begin
      xs = r.seqn_o; xa = r.arqn_o; xp = r.pend_o; xf = r.flow; xk = r.ack; xc = r.acc; xd = r.dup;
    end else begin
      xs = m_seqn; xa = m_arqn; xp = m_pend; xf = m_flow; xk = e_ack; xc = e_acc; xd = e_dup;
    end
    drive(v);
    p_1us = 1'b1;
    @(negedge clk_6M);
    chk("txaclSEQN", txaclSEQN, xs);
    chk("txARQN", txARQN, xa);
    chk("tx_pend", tx_pend, xp);
    chk("rspFLOW", 8'(rspFLOW), 8'(xf));
    chk("tx_ack_p", 8'(tx_ack_p), 8'(xk));
    chk("rx_accept_p", 8'(rx_accept_p), 8'(xc));
    chk("rx_dup_p", 8'(rx_dup_p), 8'(xd));
`ifdef ARQ_SEQN_STATS_EN
    chk("dup_cnt", dup_cnt, m_dup);
    chk("nak_cnt", nak_cnt, m_nak);
`endif
    p_1us = 1'b0; tx_packet_st_p = 1'b0; ckheader_endp = 1'b0; py_endp = 1'b0;
    @(negedge clk_6M);
    chk("pulse_width", 8'({tx_ack_p, rx_accept_p, rx_dup_p}), 8'd0);
  endtask

  row_t nr;
  vec_t iv;

  task automatic step_m(input vec_t v);
    step(v, 1'b0, nr);
  endtask

  task automatic idle_us(input int n);
    for (int i = 0; i < n; i++) step_m(iv);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    row_t tbl[21];
    vec_t v;
    iv = mk(1,0,0,0, 0,0,0,0,0,8'h00, 0,0,0);
    // Directed sequence: accept, duplicate, ACK, NAK paths and same-strobe ACK + new tx.
    tbl[0]  = rw(iv,                                          8'hff, 8'h00, 8'h00, 1,0,0,0);
    tbl[1]  = rw(mk(1,0,0,0, 1,1,2,3,1,8'h00, 0,0,0),         8'hff, 8'h00, 8'h00, 1,0,0,0);
    tbl[2]  = rw(mk(1,0,0,0, 0,0,0,0,1,8'h00, 1,1,0),         8'hff, 8'h04, 8'h00, 1,0,1,0);
    tbl[3]  = rw(mk(1,0,0,0, 1,1,2,3,1,8'h00, 0,0,0),         8'hff, 8'h04, 8'h00, 1,0,0,0);
    tbl[4]  = rw(mk(1,0,0,0, 0,0,0,0,1,8'h00, 1,1,0),         8'hff, 8'h04, 8'h00, 1,0,0,1);
    tbl[5]  = rw(mk(1,1,3,4, 0,0,0,0,0,8'h00, 0,0,0),         8'hff, 8'h04, 8'h08, 1,0,0,0);
    tbl[6]  = rw(mk(1,0,0,0, 1,1,3,0,0,8'h08, 0,0,0),         8'hf7, 8'h04, 8'h00, 1,1,0,0);
    tbl[7]  = rw(mk(1,0,0,0, 1,1,3,0,0,8'h08, 0,0,0),         8'hf7, 8'h04, 8'h00, 1,0,0,0);
    tbl[8]  = rw(mk(1,0,0,0, 1,0,2,3,0,8'h00, 0,0,0),         8'hf7, 8'h04, 8'h00, 1,0,0,0);
    tbl[9]  = rw(mk(1,0,0,0, 0,0,0,0,0,8'h00, 1,0,0),         8'hf7, 8'h04, 8'h00, 1,0,0,0);
    tbl[10] = rw(mk(1,0,0,0, 1,1,2,3,0,8'h00, 0,0,0),         8'hf7, 8'h04, 8'h00, 1,0,0,0);
    tbl[11] = rw(mk(1,0,0,0, 0,0,0,0,0,8'h00, 1,1,1),         8'hf7, 8'h00, 8'h00, 0,0,0,0);
    tbl[12] = rw(iv,                                          8'hf7, 8'h00, 8'h00, 1,0,0,0);
    tbl[13] = rw(mk(1,0,0,0, 1,1,5,3,1,8'h00, 0,0,0),         8'hf7, 8'h00, 8'h00, 1,0,0,0);
    tbl[14] = rw(mk(1,0,0,0, 0,0,0,0,1,8'h00, 1,1,0),         8'hf7, 8'h20, 8'h00, 1,0,1,0);
    tbl[15] = rw(mk(1,0,0,0, 1,1,5,3,0,8'h00, 0,0,0),         8'hf7, 8'h20, 8'h00, 1,0,0,0);
    tbl[16] = rw(mk(1,0,0,0, 0,0,0,0,0,8'h00, 1,0,0),         8'hf7, 8'h00, 8'h00, 1,0,0,0);
    tbl[17] = rw(mk(1,1,1,3, 0,0,0,0,0,8'h00, 0,0,0),         8'hf7, 8'h00, 8'h02, 1,0,0,0);
    tbl[18] = rw(mk(1,1,1,3, 1,1,1,0,0,8'h02, 0,0,0),         8'hf5, 8'h00, 8'h02, 1,1,0,0);
    tbl[19] = rw(mk(1,1,4,1, 0,0,0,0,0,8'h00, 0,0,0),         8'hf5, 8'h00, 8'h02, 1,0,0,0);
    tbl[20] = rw(mk(0,0,0,0, 0,0,0,0,0,8'h00, 0,0,0),         8'hff, 8'h00, 8'h00, 1,0,0,0);

    // Reset
    drive(iv); p_1us = 1'b0; rstz = 1'b0;
    m_reset(); now_us = 0;
    repeat (3) @(negedge clk_6M);
    rstz = 1'b1;
    @(negedge clk_6M);
    chk("rst_txaclSEQN", txaclSEQN, 8'hff);
    chk("rst_txARQN", txARQN, 8'h00);
    chk("rst_tx_pend", tx_pend, 8'h00);
    chk("rst_rspFLOW", 8'(rspFLOW), 8'd1);
    chk("rst_pulses", 8'({tx_ack_p, rx_accept_p, rx_dup_p}), 8'd0);

    for (int i = 0; i < 21; i++) step(tbl[i].v, 1'b1, tbl[i]);

    // Timeout: payload never arrives, ARQN for lt 6 drops one strobe after the timer hits 0.
    step_m(iv);
    step_m(mk(1,0,0,0, 1,1,6,3,0,8'h00, 0,0,0));
    step_m(mk(1,0,0,0, 0,0,0,0,0,8'h00, 1,1,0));
    chk("to_pre_arqn6", 8'(txARQN[6]), 8'd1);
    step_m(mk(1,0,0,0, 1,1,6,3,1,8'h00, 0,0,0));
    idle_us(PY_TIMEOUT_US);
    chk("to_last_us_arqn6", 8'(txARQN[6]), 8'd1);
    step_m(iv);
    chk("to_expired_arqn6", 8'(txARQN[6]), 8'd0);
    // Back in IDLE: the next header/payload is accepted normally.
    step_m(mk(1,0,0,0, 1,1,6,3,1,8'h00, 0,0,0));
    step_m(mk(1,0,0,0, 0,0,0,0,1,8'h00, 1,1,0));
    chk("to_recover_arqn6", 8'(txARQN[6]), 8'd1);

    // Payload end in the very strobe the timer is at 0 is still processed.
    step_m(mk(1,0,0,0, 1,1,6,3,0,8'h00, 0,0,0));
    idle_us(PY_TIMEOUT_US);
    step_m(mk(1,0,0,0, 0,0,0,0,0,8'h00, 1,1,0));
    chk("py_at_zero_arqn6", 8'(txARQN[6]), 8'd1);

    // conns drop in WAIT_PY with a payload end present: everything restored, no pulses.
    step_m(mk(1,1,3,3, 0,0,0,0,0,8'h00, 0,0,0));
    step_m(mk(1,0,0,0, 1,1,2,3,0,8'h00, 0,0,0));
    step_m(mk(0,0,0,0, 0,0,0,0,0,8'h00, 1,1,0));
    chk("drop_txaclSEQN", txaclSEQN, 8'hff);
    chk("drop_txARQN", txARQN, 8'h00);
    chk("drop_tx_pend", tx_pend, 8'h00);
`ifdef ARQ_SEQN_STATS_EN
    chk("drop_dup_cnt", dup_cnt, 8'h00);
    chk("drop_nak_cnt", nak_cnt, 8'h00);
`endif
    // Stored SEQN validity was cleared: SEQN 0 on lt 2 is a new payload.
    step_m(iv);
    step_m(mk(1,0,0,0, 1,1,2,3,0,8'h00, 0,0,0));
    step_m(mk(1,0,0,0, 0,0,0,0,0,8'h00, 1,1,0));
    chk("drop_reaccept_arqn", txARQN, 8'h04);

    // Random traffic against the model.
    step_m(mk(0,0,0,0, 0,0,0,0,0,8'h00, 0,0,0));
    for (int i = 0; i < 1500; i++) begin
      v.conns   = ($urandom_range(99) >= 2);
      v.tx      = ($urandom_range(5) == 0);
      v.tx_lt   = 3'($urandom_range(7));
      v.tx_type = 4'($urandom_range(15));
      v.hdr     = ($urandom_range(2) == 0);
      v.hec     = ($urandom_range(7) != 0);
      v.addr    = ($urandom_range(5) != 0);
      v.lt      = 3'($urandom_range(7));
      v.ptype   = 4'($urandom_range(15));
      v.seqn    = 1'($urandom_range(1));
      v.arqn    = 8'($urandom_range(255));
      v.py      = ($urandom_range(2) == 0);
      v.crc     = ($urandom_range(4) != 0);
      v.full    = ($urandom_range(7) == 0);
      step_m(v);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
